branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Branch predictor and resolver for the 5-stage pipeline.
- Predicts taken/target in Fetch using a direct-mapped BTB with 2-bit saturating counters.
- Carries each prediction down to Execute and checks it against the actual outcome there.
- Drives flush_branch, branchResolved and the redirect PC that the hazard unit and fetch logic consume.

Parameters:
- ADDR_WIDTH, 32, PC/target width.
- INDEX_BITS, 6, log2 of BTB entries (64).
- CNT_WIDTH, 16, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- PCF  in  ADDR_WIDTH  fetch PC.
- predict_takenF  out  1  fetch-stage prediction: taken.
- predict_targetF  out  ADDR_WIDTH  predicted next PC.
- stall  in  1  hazard-unit stall (load-use).
- flush  in  1  hazard-unit flush.
- branchE  in  1  Execute holds a branch/jump.
- takenE  in  1  actual outcome in Execute.
- PCE  in  ADDR_WIDTH  PC of the Execute instruction.
- targetE  in  ADDR_WIDTH  actual taken target.
- flush_branch  out  1  mispredict; flush F/D.
- branchResolved  out  1  Execute branch resolved this cycle.
- redirect_pc  out  ADDR_WIDTH  correct next PC on mispredict.
- branch_count  out  CNT_WIDTH  resolved branches.
- mispredict_count  out  CNT_WIDTH  mispredicts.

Behaviour:
- BTB storage:
  - 2^INDEX_BITS entries, each {valid, tag, target, ctr[1:0]}.
  - index = PC[INDEX_BITS+1:2]; tag = PC[ADDR_WIDTH-1:INDEX_BITS+2].
- Fetch lookup (combinational from PCF):
  - hit = valid && tag match.
  - predict_takenF = hit && ctr[1].
  - predict_targetF = predict_takenF ? target : PCF+4.
- Prediction record pipeline:
  - recD and recE registers, each {v, taken, target}.
  - Normal cycle: recD <= {1, predict_takenF, predict_targetF}; recE <= recD.
  - stall=1: recD holds; recE <= bubble (v=0).
  - flush=1 or flush_branch=1: recD <= bubble and recE <= bubble. Flush wins over stall.
- Resolution (combinational):
  - res = branchE && recE.v.
  - branchResolved = res.
  - mispredict when:
    - res && (takenE != recE.taken), or
    - res && takenE && targetE != recE.target, or
    - !branchE && recE.v && recE.taken (aliased hit on a non-branch).
  - flush_branch = mispredict.
  - redirect_pc = takenE&&branchE ? targetE : PCE+4; driven 0 when flush_branch=0.
- Table update at the clock edge when res:
  - ctr saturating: +1 if takenE (max 11), -1 otherwise (min 00).
  - If takenE: write tag, target=targetE, valid=1. A tag mismatch (new allocation) sets ctr=10 instead of incrementing.
  - Not taken on a miss: no allocation.
  - Aliased non-branch mispredict: entry valid cleared.
- Same-cycle read/write to the same index: the Fetch lookup sees the pre-update value; there is no bypass.
- Counters:
  - branch_count += res.
  - mispredict_count += mispredict.
  - Both saturate at all-ones; no wrap.
- Reset (async, any time, including mid-resolution):
  - All valid=0, all ctr=01, recD/recE bubbles, counters 0.
  - Outputs: predict_takenF=0, predict_targetF=PCF+4, flush_branch=0, branchResolved=0, redirect_pc=0.
- Latency:
  - Prediction is visible in the same cycle as PCF.
  - Outcome is known 2 cycles later in Execute (absent stall).
  - A table update is visible from the next cycle.

Test Plan:
- Reset, then PCF=0x100 → predict_takenF=0, predict_targetF=0x104. Resolve branch at 0x100 taken to 0x200 → flush_branch=1, redirect_pc=0x200; next lookup of 0x100 gives taken, 0x200 (ctr=10).
- Same branch resolved taken 3 more times, then not-taken once → ctr sequence 11,11,11,10; the not-taken resolution mispredicts with redirect_pc=0x104; the following prediction is still taken.
- stall=1 for 1 cycle while the branch is in Decode → recE bubble that cycle (branchResolved=0 even if branchE=1); the record resolves correctly the next cycle.
- Aliasing: 0x100 and 0x200 (INDEX_BITS=6) map to the same index with different tags → 0x200 misses; taken resolution of 0x200 replaces the entry; 0x100 then misses.
- Non-branch at a PC predicted taken → flush_branch=1, redirect_pc=PCE+4, entry invalidated.
- Assert rst mid-mispredict → outputs drop immediately; counters 0; all lookups miss. Drive 0x10000 resolutions → branch_count saturates at 0xFFFF.

Source files
------------

// File: rtl/branch_predict_unit_if.sv
// Branch predictor bus between the pipeline and the branch_predict_unit.
//   master : pipeline side (fetch PC, hazard controls, Execute outcome in;
//            prediction, resolution, redirect and counters out)
//   slave  : branch_predict_unit side
// Handshake: there is no valid/ready flow control on this bus. Every input is
// sampled each cycle. A branch counts as "presented" in Execute when
// branchE=1, and it is resolved only when a live prediction record sits in
// Execute in the same cycle (branchResolved=1).
interface branch_predict_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic [ADDR_WIDTH-1:0] PCF;
  logic                  predict_takenF;
  logic [ADDR_WIDTH-1:0] predict_targetF;
  logic                  stall;
  logic                  flush;
  logic                  branchE;
  logic                  takenE;
  logic [ADDR_WIDTH-1:0] PCE;
  logic [ADDR_WIDTH-1:0] targetE;
  logic                  flush_branch;
  logic                  branchResolved;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [CNT_WIDTH-1:0]  branch_count;
  logic [CNT_WIDTH-1:0]  mispredict_count;

  modport master (
    output PCF, stall, flush, branchE, takenE, PCE, targetE,
    input  predict_takenF, predict_targetF, flush_branch, branchResolved,
           redirect_pc, branch_count, mispredict_count
  );

  modport slave (
    input  PCF, stall, flush, branchE, takenE, PCE, targetE,
    output predict_takenF, predict_targetF, flush_branch, branchResolved,
           redirect_pc, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch predictor and resolver for the 5-stage pipeline.
// A direct-mapped BTB with 2-bit saturating counters predicts in Fetch; the
// prediction travels through Decode to Execute in a small record pipeline and
// is checked there against the real outcome.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bp   - branch_predict_unit_if.slave:
//          PCF -> predict_takenF/predict_targetF (combinational lookup)
//          stall/flush (hazard unit), branchE/takenE/PCE/targetE (Execute)
//          flush_branch, branchResolved, redirect_pc, branch_count,
//          mispredict_count
module branch_predict_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 6,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_predict_unit_if.slave  bp
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = ADDR_WIDTH - INDEX_BITS - 2;

  typedef struct packed {
    logic                  v;
    logic                  taken;
    logic [ADDR_WIDTH-1:0] target;
  } rec_t;

  localparam rec_t BUBBLE = '0;

  // BTB storage, kept in flops so reset can clear every entry at once.
  logic [ENTRIES-1:0]             valid_q, valid_d;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [ENTRIES-1:0][ADDR_WIDTH-1:0] target_q, target_d;
  logic [ENTRIES-1:0][1:0]        ctr_q, ctr_d;

  rec_t rec_d_q, rec_d_d;
  rec_t rec_e_q, rec_e_d;

  logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
  logic [CNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

  // Fetch lookup
  logic [INDEX_BITS-1:0] f_idx;
  logic [TAG_W-1:0]      f_tag;
  logic                  f_hit;
  logic                  pred_taken;
  logic [ADDR_WIDTH-1:0] pred_target;

  assign f_idx       = bp.PCF[INDEX_BITS+1:2];
  assign f_tag       = bp.PCF[ADDR_WIDTH-1:INDEX_BITS+2];
  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign pred_taken  = f_hit && ctr_q[f_idx][1];
  assign pred_target = pred_taken ? target_q[f_idx] : bp.PCF + ADDR_WIDTH'(4);

  // Execute resolution
  logic [INDEX_BITS-1:0] e_idx;
  logic [TAG_W-1:0]      e_tag;
  logic                  e_hit;
  logic                  res;
  logic                  alias_nb;
  logic                  mispredict;

  assign e_idx    = bp.PCE[INDEX_BITS+1:2];
  assign e_tag    = bp.PCE[ADDR_WIDTH-1:INDEX_BITS+2];
  assign e_hit    = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign res      = bp.branchE && rec_e_q.v;
  // A taken prediction reaching Execute on a non-branch came from an alias.
  assign alias_nb = !bp.branchE && rec_e_q.v && rec_e_q.taken;
  assign mispredict = (res && (bp.takenE != rec_e_q.taken))
                   || (res && bp.takenE && (bp.targetE != rec_e_q.target))
                   || alias_nb;

  // Record pipeline: a flush (hazard or mispredict) beats a stall.
  always_comb begin
    rec_d_d = rec_d_q;
    rec_e_d = rec_d_q;
    if (bp.flush || mispredict) begin
      rec_d_d = BUBBLE;
      rec_e_d = BUBBLE;
    end else if (bp.stall) begin
      rec_e_d = BUBBLE;
    end else begin
      rec_d_d = '{v: 1'b1, taken: pred_taken, target: pred_target};
    end
  end

  // Table update; the lookup above reads the pre-update state (no bypass).
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (res) begin
      if (bp.takenE) begin
        valid_d[e_idx]  = 1'b1;
        tag_d[e_idx]    = e_tag;
        target_d[e_idx] = bp.targetE;
        if (!e_hit)
          ctr_d[e_idx] = 2'b10;
        else if (ctr_q[e_idx] != 2'b11)
          ctr_d[e_idx] = ctr_q[e_idx] + 2'b01;
      end else if (e_hit && ctr_q[e_idx] != 2'b00) begin
        ctr_d[e_idx] = ctr_q[e_idx] - 2'b01;
      end
    end else if (alias_nb) begin
      valid_d[e_idx] = 1'b0;
    end
  end

  // Saturating performance counters
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (res && branch_count_q != '1)
      branch_count_d = branch_count_q + CNT_WIDTH'(1);
    if (mispredict && mispredict_count_q != '1)
      mispredict_count_d = mispredict_count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q            <= '0;
      tag_q              <= '0;
      target_q           <= '0;
      ctr_q              <= {ENTRIES{2'b01}};
      rec_d_q            <= BUBBLE;
      rec_e_q            <= BUBBLE;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      valid_q            <= valid_d;
      tag_q              <= tag_d;
      target_q           <= target_d;
      ctr_q              <= ctr_d;
      rec_d_q            <= rec_d_d;
      rec_e_q            <= rec_e_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign bp.predict_takenF   = pred_taken;
  assign bp.predict_targetF  = pred_target;
  assign bp.branchResolved   = res;
  assign bp.flush_branch     = mispredict;
  assign bp.redirect_pc      = !mispredict ? '0 :
                               (bp.takenE && bp.branchE) ? bp.targetE
                                                         : bp.PCE + ADDR_WIDTH'(4);
  assign bp.branch_count     = branch_count_q;
  assign bp.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) bp_if ();

  branch_predict_unit #(.ADDR_WIDTH(32), .INDEX_BITS(6), .CNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] FILL = 32'h0000_0904;

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bp_if.PCF     = FILL;
    bp_if.stall   = 1'b0;
    bp_if.flush   = 1'b0;
    bp_if.branchE = 1'b0;
    bp_if.takenE  = 1'b0;
    bp_if.PCE     = '0;
    bp_if.targetE = '0;
  endtask

  // Fetch pc, let it reach Execute, present the outcome there.
  task automatic run_branch(input logic [31:0] pc, input logic is_br,
                            input logic tk, input logic [31:0] tgt,
                            output logic o_pt, output logic [31:0] o_ptgt,
                            output logic o_res, output logic o_fb,
                            output logic [31:0] o_redir);
    bp_if.flush = 1'b1; bp_if.branchE = 1'b0; bp_if.PCF = FILL;
    tick();
    bp_if.flush = 1'b0; bp_if.PCF = pc;
    #1;
    o_pt   = bp_if.predict_takenF;
    o_ptgt = bp_if.predict_targetF;
    tick();
    bp_if.PCF = FILL;
    tick();
    bp_if.branchE = is_br; bp_if.PCE = pc; bp_if.takenE = tk; bp_if.targetE = tgt;
    #1;
    o_res   = bp_if.branchResolved;
    o_fb    = bp_if.flush_branch;
    o_redir = bp_if.redirect_pc;
    tick();
    bp_if.branchE = 1'b0; bp_if.takenE = 1'b0; bp_if.flush = 1'b1;
  endtask

  task automatic lookup(input logic [31:0] pc, output logic o_pt,
                        output logic [31:0] o_ptgt);
    bp_if.flush = 1'b1; bp_if.branchE = 1'b0; bp_if.PCF = pc;
    #1;
    o_pt   = bp_if.predict_takenF;
    o_ptgt = bp_if.predict_targetF;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    bp_if.PCF = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bp_if.predict_takenF !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken: got %0h want 0", bp_if.predict_takenF); end
    n_checks++; if (bp_if.predict_targetF !== 32'h104) begin n_fail++; $display("FAIL reset_pred_target: got %0h want 104", bp_if.predict_targetF); end
    n_checks++; if (bp_if.flush_branch !== 1'b0) begin n_fail++; $display("FAIL reset_flush_branch: got %0h want 0", bp_if.flush_branch); end
    n_checks++; if (bp_if.branchResolved !== 1'b0) begin n_fail++; $display("FAIL reset_resolved: got %0h want 0", bp_if.branchResolved); end
    n_checks++; if (bp_if.redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect: got %0h want 0", bp_if.redirect_pc); end
    n_checks++; if (bp_if.branch_count !== 16'h0) begin n_fail++; $display("FAIL reset_branch_count: got %0h want 0", bp_if.branch_count); end
    n_checks++; if (bp_if.mispredict_count !== 16'h0) begin n_fail++; $display("FAIL reset_mis_count: got %0h want 0", bp_if.mispredict_count); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_first_alloc;
    logic pt, res, fb; logic [31:0] ptgt, redir;
    run_branch(32'h100, 1'b1, 1'b1, 32'h200, pt, ptgt, res, fb, redir);
    n_checks++; if (pt !== 1'b0) begin n_fail++; $display("FAIL alloc_pred_taken: got %0h want 0", pt); end
    n_checks++; if (ptgt !== 32'h104) begin n_fail++; $display("FAIL alloc_pred_target: got %0h want 104", ptgt); end
    n_checks++; if (res !== 1'b1) begin n_fail++; $display("FAIL alloc_resolved: got %0h want 1", res); end
    n_checks++; if (fb !== 1'b1) begin n_fail++; $display("FAIL alloc_flush_branch: got %0h want 1", fb); end
    n_checks++; if (redir !== 32'h200) begin n_fail++; $display("FAIL alloc_redirect: got %0h want 200", redir); end
    lookup(32'h100, pt, ptgt);
    n_checks++; if (pt !== 1'b1) begin n_fail++; $display("FAIL alloc_lookup_taken: got %0h want 1", pt); end
    n_checks++; if (ptgt !== 32'h200) begin n_fail++; $display("FAIL alloc_lookup_target: got %0h want 200", ptgt); end
    n_checks++; if (bp_if.branch_count !== 16'd1) begin n_fail++; $display("FAIL alloc_branch_count: got %0d want 1", bp_if.branch_count); end
    n_checks++; if (bp_if.mispredict_count !== 16'd1) begin n_fail++; $display("FAIL alloc_mis_count: got %0d want 1", bp_if.mispredict_count); end
  endtask

  task automatic test_training;
    logic pt, res, fb; logic [31:0] ptgt, redir;
    // ctr 10 -> 11 -> 11 -> 11, all predicted correctly
    for (int i = 0; i < 3; i++) begin
      run_branch(32'h100, 1'b1, 1'b1, 32'h200, pt, ptgt, res, fb, redir);
      n_checks++; if (pt !== 1'b1 || ptgt !== 32'h200) begin n_fail++; $display("FAIL train_pred[%0d]: got %0h/%0h want 1/200", i, pt, ptgt); end
      n_checks++; if (fb !== 1'b0 || redir !== 32'h0) begin n_fail++; $display("FAIL train_no_flush[%0d]: got %0h/%0h want 0/0", i, fb, redir); end
    end
    // not taken: ctr 11 -> 10, mispredict to fall-through
    run_branch(32'h100, 1'b1, 1'b0, 32'h0, pt, ptgt, res, fb, redir);
    n_checks++; if (pt !== 1'b1) begin n_fail++; $display("FAIL nt1_pred_taken: got %0h want 1", pt); end
    n_checks++; if (fb !== 1'b1 || redir !== 32'h104) begin n_fail++; $display("FAIL nt1_redirect: got %0h/%0h want 1/104", fb, redir); end
    lookup(32'h100, pt, ptgt);
    n_checks++; if (pt !== 1'b1 || ptgt !== 32'h200) begin n_fail++; $display("FAIL nt1_lookup: got %0h/%0h want 1/200", pt, ptgt); end
    // second not taken: ctr 10 -> 01, now predicts not taken
    run_branch(32'h100, 1'b1, 1'b0, 32'h0, pt, ptgt, res, fb, redir);
    n_checks++; if (pt !== 1'b1 || fb !== 1'b1) begin n_fail++; $display("FAIL nt2_mispredict: got %0h/%0h want 1/1", pt, fb); end
    lookup(32'h100, pt, ptgt);
    n_checks++; if (pt !== 1'b0 || ptgt !== 32'h104) begin n_fail++; $display("FAIL nt2_lookup: got %0h/%0h want 0/104", pt, ptgt); end
    // taken again on a hit: ctr 01 -> 10
    run_branch(32'h100, 1'b1, 1'b1, 32'h200, pt, ptgt, res, fb, redir);
    n_checks++; if (fb !== 1'b1 || redir !== 32'h200) begin n_fail++; $display("FAIL retrain_redirect: got %0h/%0h want 1/200", fb, redir); end
    lookup(32'h100, pt, ptgt);
    n_checks++; if (pt !== 1'b1 || ptgt !== 32'h200) begin n_fail++; $display("FAIL retrain_lookup: got %0h/%0h want 1/200", pt, ptgt); end
    n_checks++; if (bp_if.branch_count !== 16'd7) begin n_fail++; $display("FAIL train_branch_count: got %0d want 7", bp_if.branch_count); end
    n_checks++; if (bp_if.mispredict_count !== 16'd4) begin n_fail++; $display("FAIL train_mis_count: got %0d want 4", bp_if.mispredict_count); end
  endtask

  task automatic test_stall;
    bp_if.flush = 1'b1; bp_if.branchE = 1'b0; bp_if.PCF = FILL;
    tick();
    bp_if.flush = 1'b0; bp_if.PCF = 32'h100;
    #1;
    n_checks++; if (bp_if.predict_takenF !== 1'b1 || bp_if.predict_targetF !== 32'h200) begin n_fail++; $display("FAIL stall_pred: got %0h/%0h want 1/200", bp_if.predict_takenF, bp_if.predict_targetF); end
    tick();
    bp_if.stall = 1'b1; bp_if.PCF = FILL;
    bp_if.branchE = 1'b1; bp_if.PCE = 32'h100; bp_if.takenE = 1'b1; bp_if.targetE = 32'h200;
    #1;
    n_checks++; if (bp_if.branchResolved !== 1'b0 || bp_if.flush_branch !== 1'b0) begin n_fail++; $display("FAIL stall_cycle_res: got %0h/%0h want 0/0", bp_if.branchResolved, bp_if.flush_branch); end
    tick();
    bp_if.stall = 1'b0;
    #1;
    n_checks++; if (bp_if.branchResolved !== 1'b0 || bp_if.flush_branch !== 1'b0) begin n_fail++; $display("FAIL stall_bubble_res: got %0h/%0h want 0/0", bp_if.branchResolved, bp_if.flush_branch); end
    tick();
    #1;
    n_checks++; if (bp_if.branchResolved !== 1'b1 || bp_if.flush_branch !== 1'b0) begin n_fail++; $display("FAIL stall_resume_res: got %0h/%0h want 1/0", bp_if.branchResolved, bp_if.flush_branch); end
    tick();
    bp_if.branchE = 1'b0; bp_if.takenE = 1'b0; bp_if.flush = 1'b1;
    n_checks++; if (bp_if.branch_count !== 16'd8) begin n_fail++; $display("FAIL stall_branch_count: got %0d want 8", bp_if.branch_count); end
  endtask

  task automatic test_alias;
    logic pt, res, fb; logic [31:0] ptgt, redir;
    lookup(32'h200, pt, ptgt);
    n_checks++; if (pt !== 1'b0 || ptgt !== 32'h204) begin n_fail++; $display("FAIL alias_miss: got %0h/%0h want 0/204", pt, ptgt); end
    run_branch(32'h200, 1'b1, 1'b1, 32'h300, pt, ptgt, res, fb, redir);
    n_checks++; if (fb !== 1'b1 || redir !== 32'h300) begin n_fail++; $display("FAIL alias_replace: got %0h/%0h want 1/300", fb, redir); end
    lookup(32'h100, pt, ptgt);
    n_checks++; if (pt !== 1'b0 || ptgt !== 32'h104) begin n_fail++; $display("FAIL alias_old_miss: got %0h/%0h want 0/104", pt, ptgt); end
    lookup(32'h200, pt, ptgt);
    n_checks++; if (pt !== 1'b1 || ptgt !== 32'h300) begin n_fail++; $display("FAIL alias_new_hit: got %0h/%0h want 1/300", pt, ptgt); end
  endtask

  task automatic test_nonbranch;
    logic pt, res, fb; logic [31:0] ptgt, redir;
    run_branch(32'h200, 1'b0, 1'b0, 32'h0, pt, ptgt, res, fb, redir);
    n_checks++; if (pt !== 1'b1 || ptgt !== 32'h300) begin n_fail++; $display("FAIL nb_pred: got %0h/%0h want 1/300", pt, ptgt); end
    n_checks++; if (res !== 1'b0) begin n_fail++; $display("FAIL nb_resolved: got %0h want 0", res); end
    n_checks++; if (fb !== 1'b1 || redir !== 32'h204) begin n_fail++; $display("FAIL nb_redirect: got %0h/%0h want 1/204", fb, redir); end
    lookup(32'h200, pt, ptgt);
    n_checks++; if (pt !== 1'b0 || ptgt !== 32'h204) begin n_fail++; $display("FAIL nb_invalidated: got %0h/%0h want 0/204", pt, ptgt); end
    n_checks++; if (bp_if.branch_count !== 16'd9 || bp_if.mispredict_count !== 16'd6) begin n_fail++; $display("FAIL nb_counts: got %0d/%0d want 9/6", bp_if.branch_count, bp_if.mispredict_count); end
  endtask

  task automatic test_reset_mid;
    logic pt, res, fb; logic [31:0] ptgt, redir;
    run_branch(32'h104, 1'b1, 1'b1, 32'h400, pt, ptgt, res, fb, redir);
    lookup(32'h104, pt, ptgt);
    n_checks++; if (pt !== 1'b1 || ptgt !== 32'h400) begin n_fail++; $display("FAIL mid_pre_hit: got %0h/%0h want 1/400", pt, ptgt); end
    bp_if.flush = 1'b0; bp_if.PCF = 32'h108;
    tick();
    bp_if.PCF = FILL;
    tick();
    bp_if.branchE = 1'b1; bp_if.PCE = 32'h108; bp_if.takenE = 1'b1; bp_if.targetE = 32'h500;
    #1;
    n_checks++; if (bp_if.flush_branch !== 1'b1 || bp_if.redirect_pc !== 32'h500) begin n_fail++; $display("FAIL mid_pre_flush: got %0h/%0h want 1/500", bp_if.flush_branch, bp_if.redirect_pc); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (bp_if.flush_branch !== 1'b0 || bp_if.branchResolved !== 1'b0) begin n_fail++; $display("FAIL mid_rst_outputs: got %0h/%0h want 0/0", bp_if.flush_branch, bp_if.branchResolved); end
    n_checks++; if (bp_if.redirect_pc !== 32'h0) begin n_fail++; $display("FAIL mid_rst_redirect: got %0h want 0", bp_if.redirect_pc); end
    n_checks++; if (bp_if.branch_count !== 16'h0 || bp_if.mispredict_count !== 16'h0) begin n_fail++; $display("FAIL mid_rst_counts: got %0h/%0h want 0/0", bp_if.branch_count, bp_if.mispredict_count); end
    n_checks++; if (bp_if.predict_takenF !== 1'b0 || bp_if.predict_targetF !== 32'h908) begin n_fail++; $display("FAIL mid_rst_pred: got %0h/%0h want 0/908", bp_if.predict_takenF, bp_if.predict_targetF); end
    bp_if.branchE = 1'b0; bp_if.takenE = 1'b0; bp_if.flush = 1'b1;
    tick();
    rst = 1'b0;
    lookup(32'h104, pt, ptgt);
    n_checks++; if (pt !== 1'b0 || ptgt !== 32'h108) begin n_fail++; $display("FAIL mid_post_miss_104: got %0h/%0h want 0/108", pt, ptgt); end
    lookup(32'h100, pt, ptgt);
    n_checks++; if (pt !== 1'b0 || ptgt !== 32'h104) begin n_fail++; $display("FAIL mid_post_miss_100: got %0h/%0h want 0/104", pt, ptgt); end
  endtask

  task automatic test_saturate;
    // Not-taken branch at a missing PC every cycle: resolves, never allocates.
    idle_inputs();
    bp_if.branchE = 1'b1; bp_if.PCE = FILL; bp_if.takenE = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (16'hFFFE + 2) tick();
    n_checks++; if (bp_if.branch_count !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre: got %0h want fffe", bp_if.branch_count); end
    repeat (3) tick();
    n_checks++; if (bp_if.branch_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_branch_count: got %0h want ffff", bp_if.branch_count); end
    n_checks++; if (bp_if.mispredict_count !== 16'h0) begin n_fail++; $display("FAIL sat_mis_count: got %0h want 0", bp_if.mispredict_count); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_first_alloc();
    test_training();
    test_stall();
    test_alias();
    test_nonbranch();
    test_reset_mid();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
